// File: rtl/ff_equiv_pkg.sv
// Shared types and helpers for the flop-mapping equivalence monitor.
package ff_equiv_pkg;

  // Monitor sequencing: idle, warm-up (samples ignored), compare window, verdict hold.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Working width for the generic saturating increment; callers cast in and out.
  localparam int unsigned SAT_W = 64;

  // Increment v, but stick at the all-ones value of a w-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned      w);
    logic [SAT_W-1:0] maxv;
    if (w >= SAT_W) maxv = '1;
    else            maxv = (SAT_W'(1) << w) - SAT_W'(1);
    return (v >= maxv) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/mism_counter.sv
// One candidate lane: compare against the reference, count mismatching
// samples with saturation, and keep a sticky fail flag.
module mism_counter
  import ff_equiv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             r,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] q_ref,
  input  logic [WIDTH-1:0] q_cand,
  output logic             mism,
  output logic             fail,
  output logic [CNTW-1:0]  count
);

  // Any differing bit makes the whole sample a mismatch for this lane.
  assign mism = (q_cand != q_ref);

  // Count and flag mismatches only while the top enables a compare sample.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      count <= '0;
      fail  <= 1'b0;
    end else if (clear) begin
      count <= '0;
      fail  <= 1'b0;
    end else if (en && mism) begin
      count <= CNTW'(sat_inc(SAT_W'(count), CNTW));
      fail  <= 1'b1;
    end
  end

endmodule

// File: rtl/ff_equiv_monitor.sv
// Clocked equivalence monitor: compares several candidate flop-output
// vectors against a reference over a fixed window after a warm-up, and
// holds a sticky per-candidate verdict until restarted.
module ff_equiv_monitor
  import ff_equiv_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NCAND      = 4,
  parameter int CNTW       = 16,
  parameter int WARMUP     = 3,
  parameter int RUN_CYCLES = 1000,
  localparam int CW        = (NCAND > 1) ? $clog2(NCAND) : 1
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic                  start,
  input  logic                  valid,
  input  logic [WIDTH-1:0]      q_ref,
  input  logic [NCAND*WIDTH-1:0] q_cand,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NCAND-1:0]      fail_mask,
  output logic [NCAND*CNTW-1:0] mism_count,
  output logic [CNTW-1:0]       sample_count,
  output logic [CNTW-1:0]       first_fail_idx,
  output logic [CW-1:0]         first_fail_cand
);

  // Terminal counts; the warm-up one is only consulted when WARMUP > 0.
  localparam logic [CNTW-1:0] WU_LAST  = CNTW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNTW-1:0] RUN_LAST = CNTW'(RUN_CYCLES - 1);
  localparam state_t          ST_FIRST = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

  state_t           state, state_nxt;
  logic             clr;
  logic             warm_en;
  logic             run_en;
  logic [CNTW-1:0]  warm_cnt;
  logic [NCAND-1:0] mism_vec;
  logic [CW-1:0]    first_k;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    warm_en   = 1'b0;
    run_en    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        // The sample presented alongside start is never consumed.
        if (start) begin
          clr       = 1'b1;
          state_nxt = ST_FIRST;
        end
      end
      ST_WARMUP: begin
        if (valid) begin
          warm_en = 1'b1;
          if (warm_cnt == WU_LAST) state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (valid) begin
          run_en = 1'b1;
          if (sample_count == RUN_LAST) state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge r) begin
    if (!r) state <= ST_IDLE;
    else    state <= state_nxt;
  end

  // One compare/count lane per candidate.
  for (genvar k = 0; k < NCAND; k++) begin : g_lane
    mism_counter #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
    ) u_lane (
      .clk    (clk),
      .r      (r),
      .clear  (clr),
      .en     (run_en),
      .q_ref  (q_ref),
      .q_cand (q_cand[k*WIDTH +: WIDTH]),
      .mism   (mism_vec[k]),
      .fail   (fail_mask[k]),
      .count  (mism_count[k*CNTW +: CNTW])
    );
  end

  // Priority select: lowest-index candidate mismatching on this sample.
  always_comb begin
    first_k = '0;
    for (int k = NCAND - 1; k >= 0; k--) begin
      if (mism_vec[k]) first_k = CW'(k);
    end
  end

  // Warm-up and sample counters plus first-fail capture; an empty fail_mask
  // means no earlier mismatch in this sequence.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      warm_cnt        <= '0;
      sample_count    <= '0;
      first_fail_idx  <= '0;
      first_fail_cand <= '0;
    end else if (clr) begin
      warm_cnt        <= '0;
      sample_count    <= '0;
      first_fail_idx  <= '0;
      first_fail_cand <= '0;
    end else begin
      if (warm_en) warm_cnt <= warm_cnt + CNTW'(1);
      if (run_en) begin
        sample_count <= sample_count + CNTW'(1);
        if ((|mism_vec) && !(|fail_mask)) begin
          first_fail_idx  <= sample_count;
          first_fail_cand <= first_k;
        end
      end
    end
  end

  assign busy = (state == ST_WARMUP) || (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && !(|fail_mask);

endmodule

// File: tb/tb_ff_equiv_monitor.sv
// Directed bench for ff_equiv_monitor with a sample-counting reference model.
module tb_ff_equiv_monitor;

  localparam int WIDTH      = 4;
  localparam int NCAND      = 4;
  localparam int CNTW       = 16;
  localparam int WARMUP     = 3;
  localparam int RUN_CYCLES = 10;
  localparam int TOTAL      = WARMUP + RUN_CYCLES;

  logic        clk = 1'b0;
  logic        r;
  logic        start, start2, s2_en, valid;
  logic [3:0]  q_ref;
  logic [15:0] q_cand;

  logic        busy, done, pass;
  logic [3:0]  fail_mask;
  logic [63:0] mism_count;
  logic [15:0] sample_count, first_fail_idx;
  logic [1:0]  first_fail_cand;

  logic        busy2, done2, pass2;
  logic [3:0]  fail_mask2;
  logic [15:0] mism_count2;
  logic [3:0]  sample_count2, first_fail_idx2;
  logic [1:0]  first_fail_cand2;

  always #5 clk = ~clk;

  ff_equiv_monitor #(
    .WIDTH(WIDTH), .NCAND(NCAND), .CNTW(CNTW), .WARMUP(WARMUP), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .r(r), .start(start), .valid(valid), .q_ref(q_ref), .q_cand(q_cand),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
    .mism_count(mism_count), .sample_count(sample_count),
    .first_fail_idx(first_fail_idx), .first_fail_cand(first_fail_cand)
  );

  ff_equiv_monitor #(
    .WIDTH(4), .NCAND(4), .CNTW(4), .WARMUP(3), .RUN_CYCLES(15)
  ) dut2 (
    .clk(clk), .r(r), .start(start2), .valid(valid), .q_ref(q_ref), .q_cand(q_cand),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail_mask2),
    .mism_count(mism_count2), .sample_count(sample_count2),
    .first_fail_idx(first_fail_idx2), .first_fail_cand(first_fail_cand2)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is just "number of valid samples seen since start";
  // the first WARMUP are ignored, the next RUN_CYCLES are judged.
  bit         m_started;
  int         m_seen;
  int         m_mism [NCAND];
  logic [3:0] m_mask;
  int         m_ffidx, m_ffcand;

  task automatic model_reset();
    m_started = 1'b0;
    m_seen    = 0;
    m_mask    = '0;
    m_ffidx   = 0;
    m_ffcand  = 0;
    for (int k = 0; k < NCAND; k++) m_mism[k] = 0;
  endtask

  task automatic model_step();
    bit any;
    if (start && (!m_started || m_seen == TOTAL)) begin
      model_reset();
      m_started = 1'b1;
    end else if (m_started && m_seen < TOTAL && valid) begin
      if (m_seen >= WARMUP) begin
        any = (m_mask != 0);
        for (int k = 0; k < NCAND; k++) begin
          if (q_cand[k*WIDTH +: WIDTH] != q_ref) begin
            if (m_mism[k] < (1 << CNTW) - 1) m_mism[k]++;
            if (!any) begin
              m_ffidx  = m_seen - WARMUP;
              m_ffcand = k;
              any      = 1'b1;
            end
            m_mask[k] = 1'b1;
          end
        end
      end
      m_seen++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge r);
      if (!r) model_reset();
      else    model_step();
    end
  end

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_started && m_seen < TOTAL);
      chk("done", done, m_started && m_seen == TOTAL);
      chk("pass", pass, m_started && m_seen == TOTAL && m_mask == 0);
      chk("fail_mask", fail_mask, m_mask);
      chk("sample_count", sample_count, (m_seen > WARMUP) ? m_seen - WARMUP : 0);
      chk("first_fail_idx", first_fail_idx, m_ffidx);
      chk("first_fail_cand", first_fail_cand, m_ffcand);
      for (int k = 0; k < NCAND; k++)
        chk($sformatf("mism_count[%0d]", k), mism_count[k*CNTW +: CNTW], m_mism[k]);
    end
  end

  function automatic logic [15:0] rep(input logic [3:0] v);
    return {4{v}};
  endfunction

  function automatic logic [15:0] flip(input logic [15:0] cd, input int k, input int b);
    logic [15:0] t;
    t = cd;
    t[k*4 + b] = ~t[k*4 + b];
    return t;
  endfunction

  // Present one cycle of inputs, let the next rising edge take it, settle.
  task automatic step(input logic s, input logic v, input logic [3:0] rf, input logic [15:0] cd);
    start  = s;
    start2 = s & s2_en;
    valid  = v;
    q_ref  = rf;
    q_cand = cd;
    @(posedge clk);
    #2;
  endtask

  task automatic run_clean_sequence(input logic [3:0] seed);
    step(1'b1, 1'b1, seed, rep(seed));
    for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b1, 4'(seed + i), rep(4'(seed + i)));
  endtask

  logic [3:0]  rf;
  logic [15:0] cd;

  initial begin
    r = 1'b1; start = 1'b0; start2 = 1'b0; s2_en = 1'b0; valid = 1'b0;
    q_ref = '0; q_cand = '0;
    #1 r = 1'b0;
    #2 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_mism", mism_count, 64'd0);
    chk("rst_ffidx", first_fail_idx, 16'd0);
    chk("rst_dut2_done", done2, 1'b0);
    r = 1'b1;
    step(1'b0, 1'b0, 4'h0, 16'h0);

    // S1: all equal, valid always high; start sample discarded, 3+10 samples.
    step(1'b1, 1'b1, 4'h5, rep(4'h5));
    for (int i = 0; i < TOTAL; i++) begin
      step(1'b0, 1'b1, 4'(i * 3 + 1), rep(4'(i * 3 + 1)));
      if (i == TOTAL - 2) chk("s1_done_not_early", done, 1'b0);
    end
    chk("s1_done", done, 1'b1);
    chk("s1_busy", busy, 1'b0);
    chk("s1_pass", pass, 1'b1);
    chk("s1_mism", mism_count, 64'd0);
    chk("s1_sample_count", sample_count, 16'd10);

    // S2: candidate 2 bit 1 flipped on RUN samples 4 and 7.
    step(1'b1, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < TOTAL; i++) begin
      rf = 4'(i + 2);
      cd = rep(rf);
      if (i - WARMUP == 4 || i - WARMUP == 7) cd = flip(cd, 2, 1);
      step(1'b0, 1'b1, rf, cd);
    end
    chk("s2_fail_mask", fail_mask, 4'b0100);
    chk("s2_mism2", mism_count[47:32], 16'd2);
    chk("s2_ffidx", first_fail_idx, 16'd4);
    chk("s2_ffcand", first_fail_cand, 2'd2);
    chk("s2_pass", pass, 1'b0);

    // S3: candidates 1 and 3 both wrong on RUN sample 0.
    step(1'b1, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < TOTAL; i++) begin
      rf = 4'(7 - i);
      cd = rep(rf);
      if (i == WARMUP) cd = flip(flip(cd, 1, 0), 3, 3);
      step(1'b0, 1'b1, rf, cd);
    end
    chk("s3_ffcand", first_fail_cand, 2'd1);
    chk("s3_fail_mask", fail_mask, 4'b1010);
    chk("s3_ffidx", first_fail_idx, 16'd0);
    chk("s3_mism3", mism_count[63:48], 16'd1);

    // S4: mismatches only in warm-up and in the discarded start sample;
    // valid toggles in RUN with garbage on invalid cycles.
    step(1'b1, 1'b1, 4'hA, rep(4'h5));
    for (int i = 0; i < WARMUP; i++) step(1'b0, 1'b1, 4'h3, ~rep(4'h3));
    for (int j = 0; j < 20; j++) begin
      if (j % 2 == 0) step(1'b0, 1'b1, 4'(j), rep(4'(j)));
      else            step(1'b0, 1'b0, 4'hF, rep(4'h0));
      if (j == 17) chk("s4_done_not_early", done, 1'b0);
      if (j == 18) chk("s4_done_after_10", done, 1'b1);
    end
    chk("s4_pass", pass, 1'b1);
    chk("s4_fail_mask", fail_mask, 4'b0000);
    chk("s4_sample_count", sample_count, 16'd10);

    // S5: 4-bit counters, 15-sample window, candidate 0 always wrong,
    // start pulsed on RUN sample 5 (must be ignored by both instances).
    s2_en = 1'b1;
    step(1'b1, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < WARMUP; i++) step(1'b0, 1'b1, 4'h9, rep(4'h9));
    for (int i = 0; i < 15; i++) begin
      rf = 4'(i);
      step(i == 5, 1'b1, rf, flip(rep(rf), 0, 0));
      if (i == 5) begin
        chk("s5_start_ignored_busy", busy2, 1'b1);
        chk("s5_start_ignored_cnt", sample_count2, 4'd6);
      end
    end
    chk("s5_done2", done2, 1'b1);
    chk("s5_mism0_nowrap", mism_count2[3:0], 4'd15);
    chk("s5_mism_other", mism_count2[15:4], 12'd0);
    chk("s5_fail_mask2", fail_mask2, 4'b0001);
    chk("s5_sample_count2", sample_count2, 4'd15);
    chk("s5_pass2", pass2, 1'b0);
    chk("s5_dut1_mism0", mism_count[15:0], 16'd10);

    // S6: reset pulse at RUN sample 5, then a clean full sequence.
    step(1'b1, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < WARMUP + 5; i++) begin
      rf = 4'(i + 4);
      cd = rep(rf);
      if (i == WARMUP + 2) cd = flip(cd, 3, 2);
      step(1'b0, 1'b1, rf, cd);
    end
    chk("s6_pre_fail_mask", fail_mask, 4'b1000);
    r = 1'b0;
    #1;
    chk("s6_rst_busy", busy, 1'b0);
    chk("s6_rst_fail_mask", fail_mask, 4'b0000);
    chk("s6_rst_mism", mism_count, 64'd0);
    chk("s6_rst_sample_count", sample_count, 16'd0);
    chk("s6_rst_ffidx", first_fail_idx, 16'd0);
    chk("s6_rst_ffcand", first_fail_cand, 2'd0);
    chk("s6_rst_dut2", mism_count2, 16'd0);
    @(posedge clk);
    #2;
    r = 1'b1;
    s2_en = 1'b0;
    step(1'b0, 1'b1, 4'h1, rep(4'h2));
    chk("s6_idle_after_rst", busy, 1'b0);
    run_clean_sequence(4'hC);
    chk("s6_done", done, 1'b1);
    chk("s6_pass", pass, 1'b1);
    chk("s6_sample_count", sample_count, 16'd10);
    step(1'b0, 1'b0, 4'h0, 16'h0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
